// File: rtl/regfile_param_sb.sv
// Parametrised 2R1W register file with optional write bypass,
// hardwired zero register, pending scoreboard and zeroing sequencer.
module regfile_param_sb #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  output logic              init_busy,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              claim_en,
  input  logic [ADDR_W-1:0] claim_addr,
  input  logic              rda_en,
  input  logic [ADDR_W-1:0] rda_addr,
  output logic [DATA_W-1:0] rda_data,
  output logic              rda_valid,
  output logic              rda_pend,
  input  logic              rdb_en,
  input  logic [ADDR_W-1:0] rdb_addr,
  output logic [DATA_W-1:0] rdb_data,
  output logic              rdb_valid,
  output logic              rdb_pend
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);

  typedef enum logic {
    S_INIT,
    S_READY
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  pend_q, pend_d;

  logic              ready, wr_ok, cl_ok;
  logic              rd_en   [2];
  logic [ADDR_W-1:0] rd_addr [2];
  logic [DATA_W-1:0] rd_dn   [2];
  logic              rd_pn   [2];
  logic [DATA_W-1:0] rd_dq   [2];
  logic              rd_vq   [2];
  logic              rd_pq   [2];

  assign ready     = (state_q == S_READY);
  assign init_busy = ~ready;
  assign wr_ok = ready & wr_en
               & ~(ZERO_REG && (wr_addr == '0));
  assign cl_ok = ready & claim_en
               & ~(ZERO_REG && (claim_addr == '0));

  assign rd_en[0]   = rda_en;
  assign rd_en[1]   = rdb_en;
  assign rd_addr[0] = rda_addr;
  assign rd_addr[1] = rdb_addr;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = S_READY;
      end
      S_READY: begin
        if (clr) begin
          state_d = S_INIT;
          cnt_d   = '0;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  // Claim is applied after the write clear so it wins on a collision.
  always_comb begin
    pend_d = pend_q;
    if (ready && clr) begin
      pend_d = '0;
    end else begin
      if (wr_ok) pend_d[wr_addr] = 1'b0;
      if (cl_ok) pend_d[claim_addr] = 1'b1;
    end
  end

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_dn[p] = mem_q[rd_addr[p]];
      rd_pn[p] = pend_q[rd_addr[p]];
      if (BYPASS && wr_en && (wr_addr == rd_addr[p])) begin
        rd_dn[p] = wr_data;
        rd_pn[p] = pend_d[rd_addr[p]];
      end
      if (ZERO_REG && (rd_addr[p] == '0)) begin
        rd_dn[p] = '0;
        rd_pn[p] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  // Array has no reset; the sequencer zeroes it instead.
  always_ff @(posedge clk) begin
    if (!ready) begin
      mem_q[cnt_q[ADDR_W-1:0]] <= '0;
    end else if (wr_ok) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < 2; p++) begin
        rd_dq[p] <= '0;
        rd_vq[p] <= 1'b0;
        rd_pq[p] <= 1'b0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (ready && !clr && rd_en[p]) begin
          rd_dq[p] <= rd_dn[p];
          rd_vq[p] <= 1'b1;
          rd_pq[p] <= rd_pn[p];
        end else begin
          rd_vq[p] <= 1'b0;
        end
      end
    end
  end

  assign rda_data  = rd_dq[0];
  assign rda_valid = rd_vq[0];
  assign rda_pend  = rd_pq[0];
  assign rdb_data  = rd_dq[1];
  assign rdb_valid = rd_vq[1];
  assign rdb_pend  = rd_pq[1];

endmodule

// File: tb/tb_regfile_param_sb.sv
// Bench for regfile_param_sb: bypass and non-bypass instances
// driven in parallel and checked against an array model.
module tb_regfile_param_sb;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clr, wr_en, claim_en, rda_en, rdb_en;
  logic [AW-1:0] wr_addr, claim_addr, rda_addr, rdb_addr;
  logic [DW-1:0] wr_data;

  logic          b_busy, n_busy;
  logic [DW-1:0] b_rda_data, b_rdb_data, n_rda_data, n_rdb_data;
  logic          b_rda_valid, b_rdb_valid, n_rda_valid, n_rdb_valid;
  logic          b_rda_pend, b_rdb_pend, n_rda_pend, n_rdb_pend;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  int            init_left;
  logic [DW-1:0] mem_m  [DEPTH];
  logic          pend_m [DEPTH];
  logic [DW-1:0] e_data  [2][2];
  logic          e_valid [2][2];
  logic          e_pend  [2][2];

  always #5 clk = ~clk;

  regfile_param_sb #(.BYPASS(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .init_busy(b_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .claim_en(claim_en), .claim_addr(claim_addr),
    .rda_en(rda_en), .rda_addr(rda_addr), .rda_data(b_rda_data),
    .rda_valid(b_rda_valid), .rda_pend(b_rda_pend),
    .rdb_en(rdb_en), .rdb_addr(rdb_addr), .rdb_data(b_rdb_data),
    .rdb_valid(b_rdb_valid), .rdb_pend(b_rdb_pend)
  );

  regfile_param_sb #(.BYPASS(1'b0)) u_n (
    .clk(clk), .rst_n(rst_n), .clr(clr), .init_busy(n_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .claim_en(claim_en), .claim_addr(claim_addr),
    .rda_en(rda_en), .rda_addr(rda_addr), .rda_data(n_rda_data),
    .rda_valid(n_rda_valid), .rda_pend(n_rda_pend),
    .rdb_en(rdb_en), .rdb_addr(rdb_addr), .rdb_data(n_rdb_data),
    .rdb_valid(n_rdb_valid), .rdb_pend(n_rdb_pend)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    init_left = DEPTH;
    for (int k = 0; k < DEPTH; k++) begin
      pend_m[k] = 1'b0;
      mem_m[k]  = '0;
    end
    for (int i = 0; i < 2; i++)
      for (int p = 0; p < 2; p++) begin
        e_data[i][p]  = '0;
        e_valid[i][p] = 1'b0;
        e_pend[i][p]  = 1'b0;
      end
  endtask

  // One clock edge of the architectural behaviour; i=0 bypass, i=1 not.
  task automatic model_step();
    logic          en;
    logic [AW-1:0] a;
    if (!rst_n) return;
    if (init_left > 0 || clr) begin
      if (init_left > 0) begin
        mem_m[DEPTH - init_left] = '0;
        init_left--;
      end else begin
        init_left = DEPTH;
        for (int k = 0; k < DEPTH; k++) pend_m[k] = 1'b0;
      end
      for (int i = 0; i < 2; i++)
        for (int p = 0; p < 2; p++) e_valid[i][p] = 1'b0;
      return;
    end
    for (int i = 0; i < 2; i++)
      for (int p = 0; p < 2; p++) begin
        en = (p == 0) ? rda_en : rdb_en;
        a  = (p == 0) ? rda_addr : rdb_addr;
        e_valid[i][p] = en;
        if (en) begin
          if (a == 0) begin
            e_data[i][p] = '0;
            e_pend[i][p] = 1'b0;
          end else if (i == 0 && wr_en && wr_addr == a) begin
            e_data[i][p] = wr_data;
            e_pend[i][p] = claim_en && claim_addr == a;
          end else begin
            e_data[i][p] = mem_m[a];
            e_pend[i][p] = pend_m[a];
          end
        end
      end
    if (wr_en && wr_addr != 0) begin
      mem_m[wr_addr]  = wr_data;
      pend_m[wr_addr] = 1'b0;
    end
    if (claim_en && claim_addr != 0) pend_m[claim_addr] = 1'b1;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    clr = 0; wr_en = 0; claim_en = 0; rda_en = 0; rdb_en = 0;
    wr_addr = '0; claim_addr = '0; rda_addr = '0; rdb_addr = '0;
    wr_data = '0;
  endtask

  task automatic count_busy(input string nm);
    int n = 0;
    while (b_busy === 1'b1 && n < 100) begin
      n++;
      cycle();
    end
    chk(nm, n, 32);
  endtask

  task automatic read_all(input string nm);
    logic [DW-1:0] orv = '0;
    logic orp = 1'b0;
    logic allv = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      rda_en = 1; rda_addr = AW'(a);
      rdb_en = 1; rdb_addr = AW'(a);
      cycle();
      orv  = orv | b_rda_data | b_rdb_data | n_rda_data;
      orp  = orp | b_rda_pend | b_rdb_pend;
      allv = allv & b_rda_valid & b_rdb_valid;
    end
    idle();
    chk({nm, "_data"}, orv, 0);
    chk({nm, "_pend"}, 32'(orp), 0);
    chk({nm, "_valid"}, 32'(allv), 1);
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("busy_b", 32'(b_busy), 32'(init_left != 0));
      chk("busy_n", 32'(n_busy), 32'(init_left != 0));
      chk("b_a_valid", 32'(b_rda_valid), 32'(e_valid[0][0]));
      chk("b_b_valid", 32'(b_rdb_valid), 32'(e_valid[0][1]));
      chk("n_a_valid", 32'(n_rda_valid), 32'(e_valid[1][0]));
      chk("n_b_valid", 32'(n_rdb_valid), 32'(e_valid[1][1]));
      chk("b_a_data", b_rda_data, e_data[0][0]);
      chk("b_b_data", b_rdb_data, e_data[0][1]);
      chk("n_a_data", n_rda_data, e_data[1][0]);
      chk("n_b_data", n_rdb_data, e_data[1][1]);
      chk("b_a_pend", 32'(b_rda_pend), 32'(e_pend[0][0]));
      chk("b_b_pend", 32'(b_rdb_pend), 32'(e_pend[0][1]));
      chk("n_a_pend", 32'(n_rda_pend), 32'(e_pend[1][0]));
      chk("n_b_pend", 32'(n_rdb_pend), 32'(e_pend[1][1]));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    idle();
    rst_n = 1;
    #1 rst_n = 0;
    model_reset();
    chk_on = 1'b1;
    #1;
    chk("rst_busy", 32'(b_busy), 1);
    chk("rst_valid", 32'(b_rda_valid), 0);
    chk("rst_data", b_rda_data, 0);
    cycle();
    cycle();
    rst_n = 1;
    count_busy("init_len");
    read_all("init_zero");

    wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF;
    cycle(); idle();
    rda_en = 1; rda_addr = 5;
    cycle(); idle();
    chk("t2_data", b_rda_data, 32'hDEADBEEF);
    chk("t2_valid", 32'(b_rda_valid), 1);
    chk("t2_pend", 32'(b_rda_pend), 0);

    wr_en = 1; wr_addr = 7; wr_data = 32'h1234;
    rdb_en = 1; rdb_addr = 7;
    cycle(); idle();
    chk("t3_bypass", b_rdb_data, 32'h1234);
    chk("t3_nobypass", n_rdb_data, 32'h0);
    rdb_en = 1; rdb_addr = 7;
    cycle(); idle();
    chk("t3_nobypass_next", n_rdb_data, 32'h1234);
    cycle();
    chk("t3_valid_drop", 32'(b_rdb_valid), 0);
    chk("t3_data_hold", b_rdb_data, 32'h1234);

    wr_en = 1; wr_addr = 0; wr_data = 32'hFFFFFFFF;
    rda_en = 1; rda_addr = 0;
    cycle(); idle();
    chk("t4_bypass_zero", b_rda_data, 0);
    rda_en = 1; rdb_en = 1;
    cycle(); idle();
    chk("t4_a_data", b_rda_data, 0);
    chk("t4_b_data", b_rdb_data, 0);
    chk("t4_b_pend", 32'(b_rdb_pend), 0);

    claim_en = 1; claim_addr = 9;
    cycle(); idle();
    rda_en = 1; rda_addr = 9;
    cycle(); idle();
    chk("t5_claim_pend", 32'(b_rda_pend), 1);
    wr_en = 1; wr_addr = 9; wr_data = 32'hAAAA;
    cycle(); idle();
    rda_en = 1; rda_addr = 9;
    cycle(); idle();
    chk("t5_write_pend", 32'(b_rda_pend), 0);
    chk("t5_write_data", b_rda_data, 32'hAAAA);
    claim_en = 1; claim_addr = 9;
    wr_en = 1; wr_addr = 9; wr_data = 32'h5555;
    cycle(); idle();
    rda_en = 1; rda_addr = 9;
    cycle(); idle();
    chk("t5_both_pend", 32'(b_rda_pend), 1);
    chk("t5_both_data", b_rda_data, 32'h5555);
    wr_en = 1; wr_addr = 9; wr_data = 32'h77;
    rda_en = 1; rda_addr = 9;
    cycle(); idle();
    chk("t5_byp_pend", 32'(b_rda_pend), 0);
    chk("t5_nobyp_pend", 32'(n_rda_pend), 1);
    chk("t5_nobyp_data", n_rda_data, 32'h5555);
    claim_en = 1; claim_addr = 0;
    cycle(); idle();
    rdb_en = 1; rdb_addr = 0;
    cycle(); idle();
    chk("t5_claim_zero", 32'(b_rdb_pend), 0);
    claim_en = 1; claim_addr = 12;
    cycle(); idle();

    clr = 1;
    cycle(); idle();
    count_busy("clr_init_len");
    read_all("clr_zero");

    wr_en = 1; wr_addr = 3; wr_data = 32'hCAFE;
    cycle(); idle();
    rda_en = 1; rda_addr = 3; rdb_en = 1; rdb_addr = 3;
    cycle(); idle();
    chk("t6_pre_data", b_rda_data, 32'hCAFE);
    clr = 1;
    cycle(); idle();
    repeat (10) cycle();
    #2 rst_n = 0;
    model_reset();
    #1;
    chk("t6_rst_a", b_rda_data, 0);
    chk("t6_rst_b", n_rdb_data, 0);
    chk("t6_rst_busy", 32'(b_busy), 1);
    cycle();
    rst_n = 1;
    count_busy("reinit_len");
    rda_en = 1; rda_addr = 3;
    cycle(); idle();
    chk("t6_after_data", b_rda_data, 0);
    cycle();

    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
